// File: rtl/mod_n_digit.sv
// Cascadable modulo-MODULUS digit (up/down, parallel load, optional saturation); q updates one edge after c_in/load.
// No backpressure: c_in is a plain enable, carry/borrow are combinational so a whole chain rolls over on one edge.
module mod_n_digit #(
    parameter int  MODULUS  = 10,
    parameter bit  SATURATE = 1'b0,
    localparam int WIDTH    = ($clog2(MODULUS) > 1) ? $clog2(MODULUS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_in,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             borrow,
    output logic             at_limit,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_ONE = WIDTH'(1);
    // One extra bit so MODULUS itself (e.g. 65536) is representable in the range check.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

    logic d_ok;
    logic q_is_max;
    logic q_is_zero;

    assign d_ok      = ({1'b0, d} < MOD_X);
    assign q_is_max  = (q == Q_MAX);
    assign q_is_zero = (q == '0);

    assign at_limit = up ? q_is_max : q_is_zero;
    assign carry    = c_in &  up & q_is_max  & ~load & ~reset & ~SATURATE;
    assign borrow   = c_in & ~up & q_is_zero & ~load & ~reset & ~SATURATE;

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if (load) begin
                if (d_ok) begin
                    q <= d;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (c_in) begin
                if (up) begin
                    if (!q_is_max) begin
                        q <= q + Q_ONE;
                    end else if (!SATURATE) begin
                        q <= '0;
                    end
                end else begin
                    if (!q_is_zero) begin
                        q <= q - Q_ONE;
                    end else if (!SATURATE) begin
                        q <= Q_MAX;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mod_n_digit.md
# mod_n_digit

Parametrised single-digit modulo-N counter for the clock/timer datapath. It generalises the fixed mod-6 seconds/minutes-tens digit to any modulus, and adds:
- up/down counting
- synchronous parallel load with range checking
- an optional saturating mode

Digits cascade by wiring one stage's `carry`/`borrow` into the next stage's `c_in`. The whole chain advances on a single clock edge.

## Interface

Parameters:
- `MODULUS`, default 10: count range 0..MODULUS-1. Legal range is 2..65536.
- `SATURATE`, default 0. When 0, the count wraps. When 1, the count holds at the limit.
- `WIDTH` (localparam) = max(1, $clog2(MODULUS)). Not overridable.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `c_in` in 1: count enable / carry-in from the less significant digit.
- `up` in 1: direction. 1 counts up, 0 counts down. Sampled only when `c_in`=1.
- `load` in 1: synchronous parallel load request.
- `d` in WIDTH: load value.
- `q` out WIDTH: current digit value (registered).
- `carry` out 1: combinational; wrap-up event this cycle.
- `borrow` out 1: combinational; wrap-down event this cycle.
- `at_limit` out 1: combinational. High when `q`==MODULUS-1 while `up`=1, or `q`==0 while `up`=0.
- `load_err` out 1: registered one-cycle pulse; flags an out-of-range load.

## Operation

- Priority at each rising edge: `reset` > `load` > count (`c_in`) > hold.
- `reset`=1: q<=0 and load_err<=0. All other inputs are ignored that cycle.
- `load`=1 with `d`<MODULUS: q<=d and load_err<=0. `c_in` is ignored that cycle.
- `load`=1 with `d`>=MODULUS: q holds and load_err<=1 for exactly one cycle. `c_in` is ignored that cycle.
- Count up (`c_in`=1, `up`=1):
  - q<MODULUS-1: q<=q+1.
  - q==MODULUS-1 with SATURATE=0: q<=0.
  - q==MODULUS-1 with SATURATE=1: q holds.
- Count down (`c_in`=1, `up`=0):
  - q>0: q<=q-1.
  - q==0 with SATURATE=0: q<=MODULUS-1.
  - q==0 with SATURATE=1: q holds.
- `c_in`=0 with no load: q holds.
- `carry` = c_in & up & (q==MODULUS-1) & ~load & ~reset & ~SATURATE.
- `borrow` = c_in & ~up & (q==0) & ~load & ~reset & ~SATURATE.
- With SATURATE=1, `carry` and `borrow` are tied to 0. Use `at_limit` to detect the limit.
- Arithmetic is WIDTH bits with no intermediate overflow. q never holds a value >=MODULUS, whatever the input sequence.
- MODULUS a power of two: wrap still uses explicit compare (same behaviour).
- Default-parameter instance reproduces a BCD units digit. MODULUS=6 with c_in tied to the units carry reproduces the legacy tens digit.

## Timing

- State: q (WIDTH flops) and load_err (1 flop). No other state.
- Reset values: q=0 and load_err=0. After reset, carry=0 and borrow=0; at_limit=~up.
- Latency: one cycle from a sampled c_in/load to the new q.
- carry/borrow are valid in the same cycle as the c_in that causes the wrap. The next digit sees them at the same edge, so an N-digit chain rolls over atomically in one cycle.
- carry/borrow are combinational from c_in, up, load and reset. Chain depth therefore adds combinational delay per digit; there is no registered carry.
- load_err asserts the cycle after the offending load and deasserts the following cycle, unless another bad load occurs.
- Reset asserted mid-count: q is 0 at the next edge, and carry/borrow are suppressed in the reset cycle.
- Simultaneous load and c_in at the terminal value: load wins and carry=0.
- Direction change: takes effect on the next edge where c_in=1; no pipeline to flush.

## Test plan

- MODULUS=6, SATURATE=0: reset, then c_in=1, up=1 for 7 cycles -> q = 1,2,3,4,5,0,1. carry is high only in the cycle q==5.
- MODULUS=10: load d=0, then c_in=1, up=0 -> q=9 after one edge with borrow=1 in the load-then-count cycle at q==0. Next edge q=8 with borrow=0.
- MODULUS=6, SATURATE=1: count up from 4 for 4 cycles -> q = 5,5,5,5, carry=0 throughout, at_limit=1 while q==5.
- MODULUS=6: load d=7 while q=3 -> q stays 3 and load_err=1 for exactly one cycle. Then load d=5 -> q=5 and load_err=0.
- Two cascaded MODULUS=10 digits, units c_in=1: after 99 edges, units=9 and tens=9 with both carries high. Next edge gives 0/0.
- q=5 (MODULUS=6) with reset and c_in both high -> q=0 next edge and carry=0 during the reset cycle. Load plus c_in at q=5 also gives carry=0.
